// File: rtl/fir_sample_feeder_if.sv
// fir_sample_feeder_if: sample-in / result-out handshake bundle for the FIR feeder
interface fir_sample_feeder_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [17:0] m_data;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: 4-tap delay line and coefficient bank feeding an external fixed-latency MAC
module fir_sample_feeder #(
  parameter int MAC_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_feeder_if.slave  bus,
  input  logic                coef_we,
  input  logic [1:0]          coef_addr,
  input  logic [7:0]          coef_data,
  output logic [7:0]          X0,
  output logic [7:0]          X1,
  output logic [7:0]          X2,
  output logic [7:0]          X3,
  output logic [7:0]          A0,
  output logic [7:0]          A1,
  output logic [7:0]          A2,
  output logic [7:0]          A3,
  output logic                fir_enable,
  input  logic [17:0]         fir_result,
  output logic                primed
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t          st, nxt;
  logic [3:0][7:0] x, a;
  logic [3:0]      wcnt;
  logic [2:0]      scnt;
  logic            accept, done;
  assign accept = bus.s_valid & bus.s_ready;
  assign done = wcnt == 4'(MAC_LATENCY - 1);
  assign bus.s_ready = (st == IDLE) & ~rst;
  assign fir_enable = st == ISSUE;
  assign primed = scnt == 3'd4;
  assign {X3, X2, X1, X0} = x;
  assign {A3, A2, A1, A0} = a;
  always_comb begin
    nxt = st;
    nxt = (st == IDLE && accept) ? ISSUE :
          (st == ISSUE) ? WAIT :
          (st == WAIT && done) ? HOLD :
          (st == HOLD && bus.m_ready) ? IDLE : st;
  end
  // coefficients are only writable in IDLE so a running MAC always sees a stable bank
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      x           <= '0;
      a           <= '0;
      wcnt        <= '0;
      scnt        <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
    end else begin
      st <= nxt;
      if (accept) begin
        x    <= {x[2:0], bus.s_data};
        scnt <= (scnt == 3'd4) ? scnt : scnt + 3'd1;
      end
      if (coef_we && st == IDLE) a[coef_addr] <= coef_data;
      wcnt <= (st == WAIT) ? wcnt + 4'd1 : 4'd0;
      if (st == WAIT && done) begin
        bus.m_data  <= fir_result;
        bus.m_valid <= 1'b1;
      end else if (st == HOLD && bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed scoreboard bench with a behavioural MAC per DUT
module tb_fir_sample_feeder;
  logic clk = 1'b0, rst = 1'b1;
  logic coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic [7:0] x0, x1, x2, x3, a0, a1, a2, a3;
  logic [7:0] y0, y1, y2, y3, b0, b1, b2, b3;
  logic fe, fe5, primed, primed5;
  logic [17:0] mac = '0, mac5 = '0;
  int tests = 0, fails = 0;
  int sb[$];
  fir_sample_feeder_if u ();
  fir_sample_feeder_if u5 ();
  always #5 clk = ~clk;
  fir_sample_feeder #(.MAC_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(u), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .X0(x0), .X1(x1), .X2(x2), .X3(x3), .A0(a0), .A1(a1), .A2(a2), .A3(a3),
    .fir_enable(fe), .fir_result(mac), .primed(primed));
  fir_sample_feeder #(.MAC_LATENCY(5)) dut5 (
    .clk(clk), .rst(rst), .bus(u5), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .X0(y0), .X1(y1), .X2(y2), .X3(y3), .A0(b0), .A1(b1), .A2(b2), .A3(b3),
    .fir_enable(fe5), .fir_result(mac5), .primed(primed5));
  always @(posedge clk) begin
    if (fe) mac <= 18'(a0) * x0 + 18'(a1) * x1 + 18'(a2) * x2 + 18'(a3) * x3;
    if (fe5) mac5 <= 18'(b0) * y0 + 18'(b1) * y1 + 18'(b2) * y2 + 18'(b3) * y3;
  end
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (u.m_valid && u.m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0d expected none", u.m_data);
      end else chk("m_data", int'(u.m_data), sb.pop_front());
    end
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = u.s_ready;
    end
    if (!ok) chk("s_ready_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    wait_ready();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    u.s_data = d;
    u.s_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 u.s_valid = 1'b0;
  endtask
  task automatic wcoef(input logic [1:0] ad, input logic [7:0] d);
    coef_we = 1'b1;
    coef_addr = ad;
    coef_data = d;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end
  initial begin
    u.s_valid = 0; u.s_data = 0; u.m_ready = 0;
    u5.s_valid = 0; u5.s_data = 0; u5.m_ready = 1;
    @(negedge clk);
    chk("s_ready_in_rst", int'(u.s_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", int'(u.s_ready), 1);
    chk("rst_m_valid", int'(u.m_valid), 0);
    chk("rst_m_data", int'(u.m_data), 0);
    chk("rst_taps", int'({x0, x1, x2, x3}), 0);
    chk("rst_coefs", int'({a0, a1, a2, a3}), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_fir_enable", int'(fe), 0);
    @(posedge clk);
    #1 u.m_ready = 1'b1;
    wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 4);
    sb.push_back(10); sb.push_back(40); sb.push_back(100); sb.push_back(200);
    send(10); send(20); send(30);
    @(negedge clk);
    chk("primed_after_3", int'(primed), 0);
    @(posedge clk);
    #1 send(40);
    @(negedge clk);
    chk("primed_after_4", int'(primed), 1);
    wait_idle();
    chk("basic_x0", int'(x0), 40); chk("basic_x1", int'(x1), 30);
    chk("basic_x2", int'(x2), 20); chk("basic_x3", int'(x3), 10);
    // the L=5 instance has zero taps, so its first result is 7*A0
    u5.s_data = 7; u5.s_valid = 1'b1;
    @(posedge clk);
    #1 u5.s_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("l5_fir_enable_k%0d", k), int'(fe5), int'(k == 1));
      chk($sformatf("l5_m_valid_k%0d", k), int'(u5.m_valid), int'(k == 7));
      if (k == 7) chk("l5_m_data", int'(u5.m_data), 7);
    end
    @(posedge clk);
    #1 u.m_ready = 1'b0;
    sb.push_back(300);
    send(50);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("l2_fir_enable_k%0d", k), int'(fe), int'(k == 1));
      chk($sformatf("l2_m_valid_k%0d", k), int'(u.m_valid), int'(k >= 4));
    end
    @(posedge clk);
    #1 u.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u.s_data = 8'(i * 17 + 3);
      @(negedge clk);
      chk("bp_m_data", int'(u.m_data), 300);
      chk("bp_s_ready", int'(u.s_ready), 0);
      chk("bp_x0", int'(x0), 50);
      @(posedge clk);
      #1;
    end
    u.s_valid = 1'b0;
    u.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_s_ready_after", int'(u.s_ready), 1);
    chk("bp_m_valid_after", int'(u.m_valid), 0);
    @(posedge clk);
    #1 sb.push_back(400);
    send(60);
    @(posedge clk);
    #1 coef_we = 1'b1; coef_addr = 0; coef_data = 9;
    @(posedge clk);
    #1 coef_we = 1'b0;
    @(negedge clk);
    chk("lockout_a0", int'(a0), 1);
    wait_idle();
    sb.push_back(1060);
    coef_we = 1'b1; coef_addr = 0; coef_data = 9;
    send(70);
    coef_we = 1'b0;
    @(negedge clk);
    chk("coincident_a0", int'(a0), 9);
    wait_idle();
    wcoef(0, 255); wcoef(1, 255); wcoef(2, 255); wcoef(3, 255);
    sb.push_back(110925); sb.push_back(163200); sb.push_back(212925); sb.push_back(260100);
    send(255); send(255); send(255); send(255);
    wait_idle();
    send(1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_m_valid", int'(u.m_valid), 0);
    chk("rstmid_taps", int'({x0, x1, x2, x3}), 0);
    chk("rstmid_coefs", int'({a0, a1, a2, a3}), 0);
    chk("rstmid_primed", int'(primed), 0);
    chk("rstmid_s_ready_in_rst", int'(u.s_ready), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rstmid_no_stray", int'(u.m_valid), 0);
      chk("rstmid_s_ready", int'(u.s_ready), 1);
    end
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
